// File: rtl/bpu_pkg.sv
// Shared types and index helpers for the two-level branch predictor.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam ctr_e PHT_RESET = WNT;

  function automatic logic [63:0] get_set(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] get_tag(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

  // gshare: word-aligned PC bits folded with global history
  function automatic logic [63:0] pht_index(input logic [63:0] pc, input logic [63:0] ghr,
                                            input int ghr_w);
    return ((pc >> 2) ^ ghr) & ((64'd1 << ghr_w) - 64'd1);
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_pht.sv
// gshare pattern history table plus global history register.
// Exposes the update-side prediction only when BPU_PERF_CNT_EN is defined.
module bpu_pht
  import bpu_pkg::*;
#(
  parameter int PC_WIDTH  = 64,
  parameter int GHR_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [PC_WIDTH-1:0] lk_pc,
  output logic                lk_taken,
  input  logic                upd_vld,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken
`ifdef BPU_PERF_CNT_EN
  ,
  output logic                upd_pred
`endif
);

  localparam int ENTRIES = 1 << GHR_WIDTH;

  logic [1:0]           pht [ENTRIES];
  logic [GHR_WIDTH-1:0] ghr;
  logic [GHR_WIDTH-1:0] lk_idx;
  logic [GHR_WIDTH-1:0] upd_idx;

  assign lk_idx   = GHR_WIDTH'(pht_index(64'(lk_pc), 64'(ghr), GHR_WIDTH));
  assign upd_idx  = GHR_WIDTH'(pht_index(64'(upd_pc), 64'(ghr), GHR_WIDTH));
  assign lk_taken = pht[lk_idx][1];
`ifdef BPU_PERF_CNT_EN
  assign upd_pred = pht[upd_idx][1];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr <= '0;
      for (int i = 0; i < ENTRIES; i++) pht[i] <= PHT_RESET;
    end else if (upd_vld) begin
      ghr          <= {ghr[GHR_WIDTH-2:0], upd_taken};
      pht[upd_idx] <= ctr_next(pht[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/bpu_two_level.sv
// Two-level BPU: 2-way LRU BTB with gshare direction prediction.
// Optional performance counters are enabled by defining BPU_PERF_CNT_EN.
module bpu_two_level
  import bpu_pkg::*;
#(
  parameter int                  PC_WIDTH  = 64,
  parameter int                  BTB_SETS  = 8,
  parameter int                  GHR_WIDTH = 6,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [PC_WIDTH-1:0] ifu_bpu_addr,
  input  logic                ifu_bpu_vaild,
  input  logic                ifu_bpu_hit_vld,
  output logic [PC_WIDTH-1:0] bpu_ifu_npc,
  output logic                bpu_ifu_pred_taken,
  output logic                bpu_ifu_btb_hit,
  input  logic                alu_bpu_upd_vld,
  input  logic [PC_WIDTH-1:0] alu_bpu_upd_pc,
  input  logic [PC_WIDTH-1:0] alu_bpu_upd_target,
  input  logic                alu_bpu_upd_taken
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]         bpu_perf_lookup,
  output logic [31:0]         bpu_perf_hit,
  output logic [31:0]         bpu_perf_mispred
`endif
);

  localparam int IDX_W = $clog2(BTB_SETS);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  // btb_lru holds the index of the least recently used way of each set
  logic                btb_vld  [BTB_SETS][2];
  logic [TAG_W-1:0]    btb_tags [BTB_SETS][2];
  logic [PC_WIDTH-1:0] btb_tgt  [BTB_SETS][2];
  logic                btb_lru  [BTB_SETS];

  logic [IDX_W-1:0]    lk_set, up_set, set_q;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                lk_hit0, lk_hit1, lk_hit, lk_way, lk_pht_taken, lk_taken;
  logic                up_hit0, up_hit1, up_hit, up_hit_way, up_alloc_way, up_way;
  logic [PC_WIDTH-1:0] lk_npc;
  logic                pend, way_q, touch;

  assign lk_set  = IDX_W'(get_set(64'(ifu_bpu_addr), IDX_W));
  assign lk_tag  = TAG_W'(get_tag(64'(ifu_bpu_addr), IDX_W));
  assign lk_hit0 = btb_vld[lk_set][0] && (btb_tags[lk_set][0] == lk_tag);
  assign lk_hit1 = btb_vld[lk_set][1] && (btb_tags[lk_set][1] == lk_tag);
  assign lk_hit  = lk_hit0 || lk_hit1;
  assign lk_way  = !lk_hit0;
  assign lk_taken = lk_hit && lk_pht_taken;
  assign lk_npc  = lk_taken ? btb_tgt[lk_set][lk_way] : ifu_bpu_addr + PC_WIDTH'(4);

  assign up_set       = IDX_W'(get_set(64'(alu_bpu_upd_pc), IDX_W));
  assign up_tag       = TAG_W'(get_tag(64'(alu_bpu_upd_pc), IDX_W));
  assign up_hit0      = btb_vld[up_set][0] && (btb_tags[up_set][0] == up_tag);
  assign up_hit1      = btb_vld[up_set][1] && (btb_tags[up_set][1] == up_tag);
  assign up_hit       = up_hit0 || up_hit1;
  assign up_hit_way   = !up_hit0;
  assign up_alloc_way = !btb_vld[up_set][0] ? 1'b0 :
                        !btb_vld[up_set][1] ? 1'b1 : btb_lru[up_set];
  assign up_way       = up_hit ? up_hit_way : up_alloc_way;

  assign touch = pend && bpu_ifu_btb_hit && ifu_bpu_hit_vld;

`ifdef BPU_PERF_CNT_EN
  logic up_pht_pred;
`endif

  bpu_pht #(.PC_WIDTH(PC_WIDTH), .GHR_WIDTH(GHR_WIDTH)) u_pht (
    .clk       (clk),
    .rstn      (rstn),
    .lk_pc     (ifu_bpu_addr),
    .lk_taken  (lk_pht_taken),
    .upd_vld   (alu_bpu_upd_vld),
    .upd_pc    (alu_bpu_upd_pc),
    .upd_taken (alu_bpu_upd_taken)
`ifdef BPU_PERF_CNT_EN
    ,
    .upd_pred  (up_pht_pred)
`endif
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bpu_ifu_npc        <= RESET_PC;
      bpu_ifu_pred_taken <= 1'b0;
      bpu_ifu_btb_hit    <= 1'b0;
      pend               <= 1'b0;
      set_q              <= '0;
      way_q              <= 1'b0;
    end else begin
      pend <= ifu_bpu_vaild;
      if (ifu_bpu_vaild) begin
        bpu_ifu_npc        <= lk_npc;
        bpu_ifu_pred_taken <= lk_taken;
        bpu_ifu_btb_hit    <= lk_hit;
        set_q              <= lk_set;
        way_q              <= lk_way;
      end
    end
  end

  // The update's LRU write comes last so it wins over a same-set touch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < BTB_SETS; s++) begin
        btb_lru[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          btb_vld[s][w]  <= 1'b0;
          btb_tags[s][w] <= '0;
          btb_tgt[s][w]  <= '0;
        end
      end
    end else begin
      if (touch) btb_lru[set_q] <= ~way_q;
      if (alu_bpu_upd_vld && alu_bpu_upd_taken) begin
        btb_vld[up_set][up_way]  <= 1'b1;
        btb_tags[up_set][up_way] <= up_tag;
        btb_tgt[up_set][up_way]  <= alu_bpu_upd_target;
        btb_lru[up_set]          <= ~up_way;
      end
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic up_pred_taken, up_mispred;

  assign up_pred_taken = up_hit && up_pht_pred;
  assign up_mispred    = (up_pred_taken != alu_bpu_upd_taken) ||
                         (alu_bpu_upd_taken && btb_tgt[up_set][up_hit_way] != alu_bpu_upd_target);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bpu_perf_lookup  <= '0;
      bpu_perf_hit     <= '0;
      bpu_perf_mispred <= '0;
    end else begin
      if (ifu_bpu_vaild) bpu_perf_lookup <= bpu_perf_lookup + 32'd1;
      if (touch) bpu_perf_hit <= bpu_perf_hit + 32'd1;
      if (alu_bpu_upd_vld && up_mispred) bpu_perf_mispred <= bpu_perf_mispred + 32'd1;
    end
  end
`endif

endmodule
